// File: rtl/pipe_pkg.sv
// Shared types and constants for the 8-bit pipeline hazard/stall control.
package pipe_pkg;

  localparam int REG_NUM_W   = 3;
  localparam int NUM_REGS    = 8;
  localparam int SB_W        = 2;
  localparam int LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

endpackage

// File: rtl/hz_scoreboard.sv
// Per-register countdown of edges until an in-flight write reaches the register file.
module hz_scoreboard
  import pipe_pkg::*;
#(
  parameter int LAT = LAT_DEFAULT
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Adv_i,
  input  logic                 Set_i,
  input  logic [REG_NUM_W-1:0] Set_Num_i,
  input  logic [REG_NUM_W-1:0] Rd1_Num_i,
  input  logic [REG_NUM_W-1:0] Rd2_Num_i,
  output logic                 Rd1_Busy_o,
  output logic                 Rd2_Busy_o,
  output logic                 All_Zero_o
);

  logic [NUM_REGS-1:0][SB_W-1:0] sb_q, sb_d;

  // A fresh issue overrides the countdown on the same entry.
  always_comb begin
    sb_d = sb_q;
    if (Adv_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (Set_i && (Set_Num_i == REG_NUM_W'(i)))
          sb_d[i] = SB_W'(LAT);
        else if (sb_q[i] != '0)
          sb_d[i] = sb_q[i] - SB_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  assign Rd1_Busy_o = |sb_q[Rd1_Num_i];
  assign Rd2_Busy_o = |sb_q[Rd2_Num_i];
  assign All_Zero_o = ~|sb_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// RAW hazard detection, pipeline register enables/flush/bubble, debug drain FSM, stall counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int LAT   = LAT_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 ID_Valid,
  input  logic [REG_NUM_W-1:0] ID_Src1_Num,
  input  logic                 ID_Src1_Used,
  input  logic [REG_NUM_W-1:0] ID_Src2_Num,
  input  logic                 ID_Src2_Used,
  input  logic [REG_NUM_W-1:0] ID_Write_Reg_Num,
  input  logic                 ID_RegWrite,
  input  logic                 Flush,
  input  logic                 Mem_Busy,
  input  logic                 Drain_Req,
  output logic                 PC_Write_En,
  output logic                 IF_ID_Write_En,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Write_En,
  output logic                 ID_EX_Bubble,
  output logic                 Issue,
  output logic                 Drained,
  output logic [CNT_W-1:0]     Stall_Count
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd1_busy, rd2_busy, all_zero;
  logic             haz, hz_stall;

  hz_scoreboard #(.LAT(LAT)) u_sb (
    .Clk        (Clk),
    .Reset      (Reset),
    .Adv_i      (~Mem_Busy),
    .Set_i      (Issue & ID_RegWrite),
    .Set_Num_i  (ID_Write_Reg_Num),
    .Rd1_Num_i  (ID_Src1_Num),
    .Rd1_Busy_o (rd1_busy),
    .Rd2_Num_i  (ID_Src2_Num),
    .Rd2_Busy_o (rd2_busy),
    .All_Zero_o (all_zero)
  );

  assign haz = ID_Valid & ((ID_Src1_Used & rd1_busy) | (ID_Src2_Used & rd2_busy));

  always_comb begin
    PC_Write_En    = 1'b1;
    IF_ID_Write_En = 1'b1;
    IF_ID_Flush    = 1'b0;
    ID_EX_Write_En = 1'b1;
    ID_EX_Bubble   = ~ID_Valid;
    Issue          = ID_Valid;
    hz_stall       = 1'b0;
    if (Mem_Busy) begin
      // Whole-pipe freeze; the branch unit keeps Flush asserted until released.
      PC_Write_En    = 1'b0;
      IF_ID_Write_En = 1'b0;
      ID_EX_Write_En = 1'b0;
      ID_EX_Bubble   = 1'b0;
      Issue          = 1'b0;
    end else if (state_q != RUN) begin
      PC_Write_En    = 1'b0;
      IF_ID_Write_En = 1'b0;
      ID_EX_Bubble   = 1'b1;
      Issue          = 1'b0;
    end else if (Flush) begin
      IF_ID_Flush    = 1'b1;
      ID_EX_Bubble   = 1'b1;
      Issue          = 1'b0;
    end else if (haz) begin
      PC_Write_En    = 1'b0;
      IF_ID_Write_En = 1'b0;
      ID_EX_Bubble   = 1'b1;
      Issue          = 1'b0;
      hz_stall       = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (Drain_Req) state_d = DRAIN;
      DRAIN:   if (!Drain_Req) state_d = RUN;
               else if (all_zero && !Mem_Busy) state_d = HALTED;
      HALTED:  if (!Drain_Req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign cnt_d = (hz_stall && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Drained     = (state_q == HALTED);
  assign Stall_Count = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a ready-time reference model checked every cycle.
module tb_pipe_hazard_ctrl;

  localparam int LATP = 2;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          ID_Valid = 1'b0;
  logic [2:0]    ID_Src1_Num = '0;
  logic          ID_Src1_Used = 1'b0;
  logic [2:0]    ID_Src2_Num = '0;
  logic          ID_Src2_Used = 1'b0;
  logic [2:0]    ID_Write_Reg_Num = '0;
  logic          ID_RegWrite = 1'b0;
  logic          Flush = 1'b0;
  logic          Mem_Busy = 1'b0;
  logic          Drain_Req = 1'b0;
  logic          PC_Write_En, IF_ID_Write_En, IF_ID_Flush, ID_EX_Write_En;
  logic          ID_EX_Bubble, Issue, Drained;
  logic [CW-1:0] Stall_Count;

  pipe_hazard_ctrl #(.LAT(LATP), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .ID_Valid(ID_Valid),
    .ID_Src1_Num(ID_Src1_Num), .ID_Src1_Used(ID_Src1_Used),
    .ID_Src2_Num(ID_Src2_Num), .ID_Src2_Used(ID_Src2_Used),
    .ID_Write_Reg_Num(ID_Write_Reg_Num), .ID_RegWrite(ID_RegWrite),
    .Flush(Flush), .Mem_Busy(Mem_Busy), .Drain_Req(Drain_Req),
    .PC_Write_En(PC_Write_En), .IF_ID_Write_En(IF_ID_Write_En),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Write_En(ID_EX_Write_En),
    .ID_EX_Bubble(ID_EX_Bubble), .Issue(Issue), .Drained(Drained),
    .Stall_Count(Stall_Count)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model: a register is readable once the count of unfrozen edges reaches rdy[r].
  int act = 0;
  int rdy[8] = '{default: 0};
  int mode = 0;  // 0 running, 1 draining, 2 halted
  int stalls = 0;
  bit m_haz, m_idle, e_pc, e_ifid, e_fl, e_idex, e_bub, e_iss, e_st;

  always @(negedge Clk) begin
    if (Reset) begin
      act = 0; mode = 0; stalls = 0;
      foreach (rdy[i]) rdy[i] = 0;
    end
    m_haz = ID_Valid && ((ID_Src1_Used && act < rdy[ID_Src1_Num]) ||
                         (ID_Src2_Used && act < rdy[ID_Src2_Num]));
    m_idle = 1'b1;
    foreach (rdy[i]) if (act < rdy[i]) m_idle = 1'b0;
    {e_pc, e_ifid, e_fl, e_idex, e_bub, e_iss, e_st} = {1'b1, 1'b1, 1'b0, 1'b1, !ID_Valid, ID_Valid, 1'b0};
    if (Mem_Busy)       {e_pc, e_ifid, e_fl, e_idex, e_bub, e_iss} = 6'b000000;
    else if (mode != 0) {e_pc, e_ifid, e_fl, e_idex, e_bub, e_iss} = 6'b000110;
    else if (Flush)     {e_pc, e_ifid, e_fl, e_idex, e_bub, e_iss} = 6'b111110;
    else if (m_haz)   begin {e_pc, e_ifid, e_fl, e_idex, e_bub, e_iss} = 6'b000110; e_st = 1'b1; end
    chk("m_pc_we",   PC_Write_En,    e_pc);
    chk("m_ifid_we", IF_ID_Write_En, e_ifid);
    chk("m_ifid_fl", IF_ID_Flush,    e_fl);
    chk("m_idex_we", ID_EX_Write_En, e_idex);
    chk("m_bubble",  ID_EX_Bubble,   e_bub);
    chk("m_issue",   Issue,          e_iss);
    chk("m_drained", Drained,        mode == 2);
    chk("m_stalls",  Stall_Count,    stalls);
    case (mode)
      0: if (Drain_Req) mode = 1;
      1: if (!Drain_Req) mode = 0; else if (m_idle && !Mem_Busy) mode = 2;
      default: if (!Drain_Req) mode = 0;
    endcase
    if (!Mem_Busy) begin
      if (e_iss && ID_RegWrite) rdy[ID_Write_Reg_Num] = act + 1 + LATP;
      act++;
    end
    if (e_st && stalls < CMAX) stalls++;
  end

  task automatic tick;
    @(posedge Clk); #1;
  endtask

  task automatic set_id(input bit v, input int s1, input bit u1, input int s2, input bit u2,
                        input int wd, input bit rw);
    ID_Valid = v;
    ID_Src1_Num = 3'(s1); ID_Src1_Used = u1;
    ID_Src2_Num = 3'(s2); ID_Src2_Used = u2;
    ID_Write_Reg_Num = 3'(wd); ID_RegWrite = rw;
  endtask

  // Holds the current ID instruction until it issues; n = cycles spent stalled.
  task automatic wait_issue(output int n);
    bit done;
    n = 0; done = 0;
    while (!done) begin
      @(negedge Clk);
      if (Issue === 1'b1) done = 1;
      else begin
        n++;
        if (n > 20) begin
          checks++; errors++;
          $display("FAIL issue_timeout: no Issue within 20 cycles");
          done = 1;
        end else tick();
      end
    end
    tick();
    ID_Valid = 1'b0;
  endtask

  task automatic do_reset;
    Reset = 1'b1;
    @(negedge Clk); #2;
    Reset = 1'b0;
    tick();
  endtask

  int n;

  initial begin
    @(negedge Clk);
    chk("rst_pc_we", PC_Write_En, 1);
    chk("rst_idex_we", ID_EX_Write_En, 1);
    chk("rst_bubble", ID_EX_Bubble, 1);
    chk("rst_issue", Issue, 0);
    chk("rst_drained", Drained, 0);
    chk("rst_cnt", Stall_Count, 0);
    #2 Reset = 1'b0;
    tick();

    // Producer r3 then dependent reader: two stall cycles.
    set_id(1, 0, 0, 0, 0, 3, 1); wait_issue(n); chk("t1_prod_n", n, 0);
    set_id(1, 3, 1, 0, 0, 0, 0); wait_issue(n); chk("t1_cons_n", n, 2);
    chk("t1_cnt", Stall_Count, 2);

    // Independent writes issue back to back.
    do_reset();
    set_id(1, 0, 0, 0, 0, 1, 1); wait_issue(n); chk("t2_r1_n", n, 0);
    set_id(1, 6, 1, 0, 0, 2, 1); wait_issue(n); chk("t2_r2_n", n, 0);
    set_id(1, 5, 1, 7, 1, 4, 1); wait_issue(n); chk("t2_r4_n", n, 0);
    chk("t2_cnt", Stall_Count, 0);

    // Consumer of r5 frozen by Mem_Busy for 4 cycles.
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1); wait_issue(n);
    set_id(1, 0, 0, 5, 1, 0, 0);
    @(negedge Clk); chk("t3_first_stall", Issue, 0);
    tick();
    Mem_Busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("t3_busy_pc", PC_Write_En, 0);
      chk("t3_busy_ifid", IF_ID_Write_En, 0);
      chk("t3_busy_idex", ID_EX_Write_En, 0);
      tick();
    end
    Mem_Busy = 1'b0;
    wait_issue(n); chk("t3_after_busy_n", n, 1);
    chk("t3_cnt", Stall_Count, 2);

    // Flush over a hazarding instruction: no scoreboard set for its destination.
    do_reset();
    set_id(1, 0, 0, 0, 0, 2, 1); wait_issue(n);
    set_id(1, 2, 1, 0, 0, 3, 1); Flush = 1'b1;
    @(negedge Clk);
    chk("t4_flush", IF_ID_Flush, 1);
    chk("t4_bubble", ID_EX_Bubble, 1);
    chk("t4_pc_we", PC_Write_En, 1);
    chk("t4_issue", Issue, 0);
    tick();
    Flush = 1'b0;
    set_id(1, 3, 1, 0, 0, 0, 0); wait_issue(n); chk("t4_r3_n", n, 0);
    chk("t4_cnt", Stall_Count, 0);

    // Drain after a write to r7, then resume.
    do_reset();
    set_id(1, 0, 0, 0, 0, 7, 1); wait_issue(n);
    Drain_Req = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && Drained !== 1'b1; i++) begin
      @(negedge Clk);
      if (Drained !== 1'b1) begin
        n++;
        if (n == 2) chk("t5_drain_pc", PC_Write_En, 0);
        tick();
      end
    end
    chk("t5_cycles_to_drained", n, 3);
    tick();
    Drain_Req = 1'b0;
    set_id(1, 7, 1, 0, 0, 1, 1); wait_issue(n); chk("t5_resume_n", n, 1);

    // Reset while sb[6]=2: the reader of r6 issues at once.
    do_reset();
    set_id(1, 0, 0, 0, 0, 6, 1); wait_issue(n);
    set_id(1, 6, 1, 0, 0, 0, 0);
    Reset = 1'b1;
    @(negedge Clk); chk("t6_issue_in_rst", Issue, 1);
    #2 Reset = 1'b0;
    tick();
    ID_Valid = 1'b0;
    chk("t6_cnt", Stall_Count, 0);
    set_id(1, 0, 0, 6, 1, 0, 0); wait_issue(n); chk("t6_r6_n", n, 0);

    // Destination equal to source, then stall counter saturation.
    do_reset();
    set_id(1, 1, 1, 0, 0, 1, 1); wait_issue(n); chk("t7_self_n", n, 0);
    set_id(1, 1, 1, 0, 0, 1, 1); wait_issue(n); chk("t7_self_dep_n", n, 2);
    for (int i = 0; i < 4; i++) begin
      set_id(1, 0, 0, 0, 0, 4, 1); wait_issue(n);
      set_id(1, 0, 0, 4, 1, 0, 0); wait_issue(n);
    end
    chk("t7_cnt_sat", Stall_Count, CMAX);

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
